generic_fetch_engine: RTL

GENERIC_FETCH_ENGINE -- requirements
Module: generic_fetch_engine

---
 rtl/generic_fetch_engine.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/generic_fetch_engine.sv
// generic_fetch_engine: streams fetch_count beats from an external source into
// one of NUM_CH on-chip buffers. Read requests are issued under rd_ready flow
// control. Each write's sideband rides an RD_LAT-deep pipeline so that it meets
// its read data, with stalls and bubbles preserved.
module generic_fetch_engine #(
    parameter int                 DATA_W      = 128,
    parameter int                 SRC_AW      = 32,
    parameter int                 DST_AW      = 15,
    parameter int                 CNT_W       = 8,
    parameter int                 NUM_CH      = 4,
    parameter int                 RD_LAT      = 1,
    parameter logic [SRC_AW-1:0]  ADDR_OFFSET = '0,
    localparam int                CH_W        = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [SRC_AW-1:0] src_addr,
    input  logic [DST_AW-1:0] dst_addr,
    input  logic [CNT_W-1:0]  fetch_count,
    input  logic              dst_hold,
    output logic              rd_en,
    output logic [SRC_AW-1:0] rd_addr,
    input  logic              rd_ready,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [DST_AW-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [NUM_CH-1:0] wr_cs,
    output logic              busy,
    output logic              done,
    output logic              err_busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                          state_q, state_d;
    logic [SRC_AW-1:0]               rd_addr_q, rd_addr_d;   // address of the next beat
    logic [CNT_W-1:0]                rem_q, rem_d;           // beats still to be accepted
    logic [DST_AW-1:0]               dst_q, dst_d;           // write address of the next beat
    logic                            hold_q, hold_d;
    logic [NUM_CH-1:0]               cs_q, cs_d;             // latched one-hot buffer select
    logic                            err_q, err_d;
    logic [RD_LAT:1]                 vld_pipe_q, vld_pipe_d;
    logic [RD_LAT:1][DST_AW-1:0]     addr_pipe_q, addr_pipe_d;
    logic [RD_LAT:1][NUM_CH-1:0]     cs_pipe_q, cs_pipe_d;

    logic            accept;
    logic            pend;
    logic [CH_W-1:0] ch_mod;

    // Out-of-range channel indices fold back into the valid range.
    assign ch_mod = CH_W'(32'(ch_sel) % NUM_CH);

    // Next-state, command latching and write-sideband pipeline shift.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rem_d     = rem_q;
        dst_d     = dst_q;
        hold_d    = hold_q;
        cs_d      = cs_q;
        err_d     = start && (state_q != S_IDLE);
        accept    = (state_q == S_ISSUE) && rd_ready;

        // Any beat still short of the last stage means more writes are coming.
        pend = 1'b0;
        for (int i = 1; i < RD_LAT; i++) pend = pend | vld_pipe_q[i];

        vld_pipe_d[1]  = accept;
        addr_pipe_d[1] = accept ? dst_q : '0;
        cs_pipe_d[1]   = accept ? cs_q : '0;
        for (int i = 2; i <= RD_LAT; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            addr_pipe_d[i] = addr_pipe_q[i-1];
            cs_pipe_d[i]   = cs_pipe_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (fetch_count != '0) begin
                        rd_addr_d = src_addr + ADDR_OFFSET;
                        rem_d     = fetch_count;
                        dst_d     = dst_addr;
                        hold_d    = dst_hold;
                        cs_d      = NUM_CH'(1) << ch_mod;
                        state_d   = S_ISSUE;
                    end else begin
                        state_d   = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                if (rd_ready) begin
                    rd_addr_d = rd_addr_q + SRC_AW'(1);
                    rem_d     = rem_q - CNT_W'(1);
                    if (!hold_q) dst_d = dst_q + DST_AW'(1);
                    if (rem_q == CNT_W'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave once the final write is on the bus this cycle.
                if (!pend) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any command and drops in-flight writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            rem_q       <= '0;
            dst_q       <= '0;
            hold_q      <= 1'b0;
            cs_q        <= '0;
            err_q       <= 1'b0;
            vld_pipe_q  <= '0;
            addr_pipe_q <= '0;
            cs_pipe_q   <= '0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            rem_q       <= rem_d;
            dst_q       <= dst_d;
            hold_q      <= hold_d;
            cs_q        <= cs_d;
            err_q       <= err_d;
            vld_pipe_q  <= vld_pipe_d;
            addr_pipe_q <= addr_pipe_d;
            cs_pipe_q   <= cs_pipe_d;
        end
    end

    assign rd_en    = (state_q == S_ISSUE);
    assign rd_addr  = rd_addr_q;
    assign wr_en    = vld_pipe_q[RD_LAT];
    assign wr_addr  = addr_pipe_q[RD_LAT];
    assign wr_cs    = cs_pipe_q[RD_LAT];
    // Read data lands in its write cycle; it only reaches the bus on valid beats.
    assign wr_data  = wr_en ? rd_data : '0;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign err_busy = err_q;

endmodule
